// File: rtl/fft_pkg.sv
// Shared types and constants for the iterative 8-point FFT/IFFT family.
// Twiddles are Q8.8; the table here holds the conjugated (inverse) set.
package fft_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC_W = 8;
  localparam int TW_W       = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // Entry t is conj(W8^t): (256,0) (181,181) (0,256) (-181,181)
  localparam logic [3:0][TW_W-1:0] TW_RE = {
    16'hFF4B, 16'h0000, 16'h00B5, 16'h0100
  };
  localparam logic [3:0][TW_W-1:0] TW_IM = {
    16'h00B5, 16'h0100, 16'h00B5, 16'h0000
  };

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/ifft_butterfly.sv
// Radix-2 DIT butterfly: a +/- b*w, halved, saturated.
// Twiddle sign selects inverse or forward direction.
module ifft_butterfly #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int TW_W   = 16
) (
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic signed [TW_W-1:0]   w_re,
  input  logic signed [TW_W-1:0]   w_im,
  output logic signed [DATA_W-1:0] ya_re,
  output logic signed [DATA_W-1:0] ya_im,
  output logic signed [DATA_W-1:0] yb_re,
  output logic signed [DATA_W-1:0] yb_im
);

  localparam int MW = DATA_W + TW_W;
  localparam int PW = MW + 1;
  localparam int SW = DATA_W + 2;

  localparam logic signed [SW-1:0] MAXV =
    SW'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = -MAXV - SW'(1);

  function automatic logic signed [DATA_W-1:0] sat(
    input logic signed [SW-1:0] v
  );
    if (v > MAXV) return MAXV[DATA_W-1:0];
    if (v < MINV) return MINV[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  logic signed [MW-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [PW-1:0] pr_full, pi_full;
  logic signed [SW-1:0] p_re, p_im;
  logic signed [SW-1:0] s_re, s_im, d_re, d_im;

  // Complex multiply, floor-shift, then (a +/- p)/2 with saturation
  always_comb begin
    m_rr    = MW'(b_re) * MW'(w_re);
    m_ii    = MW'(b_im) * MW'(w_im);
    m_ri    = MW'(b_re) * MW'(w_im);
    m_ir    = MW'(b_im) * MW'(w_re);
    pr_full = PW'(m_rr) - PW'(m_ii);
    pi_full = PW'(m_ri) + PW'(m_ir);
    p_re    = SW'(pr_full >>> FRAC_W);
    p_im    = SW'(pi_full >>> FRAC_W);
    s_re    = (SW'(a_re) + p_re) >>> 1;
    s_im    = (SW'(a_im) + p_im) >>> 1;
    d_re    = (SW'(a_re) - p_re) >>> 1;
    d_im    = (SW'(a_im) - p_im) >>> 1;
    ya_re   = sat(s_re);
    ya_im   = sat(s_im);
    yb_re   = sat(d_re);
    yb_im   = sat(d_im);
  end

endmodule

// File: rtl/eight_point_ifft.sv
// Iterative 8-point radix-2 DIT inverse FFT, one butterfly per cycle.
// Load bank keeps the input so a repeated start recomputes the same result.
module eight_point_ifft
  import fft_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic signed [DATA_W-1:0] in0_real,
  input  logic signed [DATA_W-1:0] in1_real,
  input  logic signed [DATA_W-1:0] in2_real,
  input  logic signed [DATA_W-1:0] in3_real,
  input  logic signed [DATA_W-1:0] in4_real,
  input  logic signed [DATA_W-1:0] in5_real,
  input  logic signed [DATA_W-1:0] in6_real,
  input  logic signed [DATA_W-1:0] in7_real,
  input  logic signed [DATA_W-1:0] in0_imag,
  input  logic signed [DATA_W-1:0] in1_imag,
  input  logic signed [DATA_W-1:0] in2_imag,
  input  logic signed [DATA_W-1:0] in3_imag,
  input  logic signed [DATA_W-1:0] in4_imag,
  input  logic signed [DATA_W-1:0] in5_imag,
  input  logic signed [DATA_W-1:0] in6_imag,
  input  logic signed [DATA_W-1:0] in7_imag,
  input  logic                     write,
  input  logic                     start,
  output logic signed [DATA_W-1:0] out0_real,
  output logic signed [DATA_W-1:0] out1_real,
  output logic signed [DATA_W-1:0] out2_real,
  output logic signed [DATA_W-1:0] out3_real,
  output logic signed [DATA_W-1:0] out4_real,
  output logic signed [DATA_W-1:0] out5_real,
  output logic signed [DATA_W-1:0] out6_real,
  output logic signed [DATA_W-1:0] out7_real,
  output logic signed [DATA_W-1:0] out0_imag,
  output logic signed [DATA_W-1:0] out1_imag,
  output logic signed [DATA_W-1:0] out2_imag,
  output logic signed [DATA_W-1:0] out3_imag,
  output logic signed [DATA_W-1:0] out4_imag,
  output logic signed [DATA_W-1:0] out5_imag,
  output logic signed [DATA_W-1:0] out6_imag,
  output logic signed [DATA_W-1:0] out7_imag,
  output logic                     ready
);

  state_t state, state_nx;
  logic [3:0] cnt;
  logic load_en, go_en, bf_en, fin_en;
  logic [2:0] top, bot;
  logic [1:0] tw;

  logic signed [DATA_W-1:0] in_re[8], in_im[8];
  logic signed [DATA_W-1:0] ld_re[8], ld_im[8];
  logic signed [DATA_W-1:0] wk_re[8], wk_im[8];
  logic signed [DATA_W-1:0] res_re[8], res_im[8];
  logic signed [DATA_W-1:0] ya_re, ya_im, yb_re, yb_im;

  assign in_re = '{in0_real, in1_real, in2_real, in3_real,
                   in4_real, in5_real, in6_real, in7_real};
  assign in_im = '{in0_imag, in1_imag, in2_imag, in3_imag,
                   in4_imag, in5_imag, in6_imag, in7_imag};

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state and command decode; write beats start
  always_comb begin
    state_nx = state;
    load_en  = 1'b0;
    go_en    = 1'b0;
    bf_en    = 1'b0;
    fin_en   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (write) begin
          load_en  = 1'b1;
          state_nx = S_IDLE;
        end else if (start) begin
          go_en    = 1'b1;
          state_nx = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (cnt == 4'd12) begin
          fin_en   = 1'b1;
          state_nx = S_DONE;
        end else begin
          bf_en = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Butterfly pair and twiddle for counter value: stage cnt[3:2], j cnt[1:0]
  always_comb begin
    top = '0;
    bot = '0;
    tw  = '0;
    case (cnt[3:2])
      2'd0: begin
        top = {cnt[1:0], 1'b0};
        bot = {cnt[1:0], 1'b1};
      end
      2'd1: begin
        top = {cnt[1], 1'b0, cnt[0]};
        bot = {cnt[1], 1'b1, cnt[0]};
        tw  = {cnt[0], 1'b0};
      end
      2'd2: begin
        top = {1'b0, cnt[1:0]};
        bot = {1'b1, cnt[1:0]};
        tw  = cnt[1:0];
      end
      default: ;
    endcase
  end

  ifft_butterfly #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .TW_W   (TW_W)
  ) u_bf (
    .a_re  (wk_re[top]),
    .a_im  (wk_im[top]),
    .b_re  (wk_re[bot]),
    .b_im  (wk_im[bot]),
    .w_re  (TW_RE[tw]),
    .w_im  (TW_IM[tw]),
    .ya_re (ya_re),
    .ya_im (ya_im),
    .yb_re (yb_re),
    .yb_im (yb_im)
  );

  // Load bank, in-place working regs, counter, result regs, ready
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt   <= '0;
      ready <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        ld_re[k]  <= '0;
        ld_im[k]  <= '0;
        wk_re[k]  <= '0;
        wk_im[k]  <= '0;
        res_re[k] <= '0;
        res_im[k] <= '0;
      end
    end else begin
      if (load_en) begin
        ready <= 1'b0;
        for (int k = 0; k < 8; k++) begin
          ld_re[bitrev3(3'(k))] <= in_re[k];
          ld_im[bitrev3(3'(k))] <= in_im[k];
        end
      end
      if (go_en) begin
        ready <= 1'b0;
        cnt   <= '0;
        wk_re <= ld_re;
        wk_im <= ld_im;
      end
      if (bf_en) begin
        wk_re[top] <= ya_re;
        wk_im[top] <= ya_im;
        wk_re[bot] <= yb_re;
        wk_im[bot] <= yb_im;
        cnt        <= cnt + 4'd1;
      end
      if (fin_en) begin
        res_re <= wk_re;
        res_im <= wk_im;
        ready  <= 1'b1;
      end
    end
  end

  assign out0_real = res_re[0];
  assign out1_real = res_re[1];
  assign out2_real = res_re[2];
  assign out3_real = res_re[3];
  assign out4_real = res_re[4];
  assign out5_real = res_re[5];
  assign out6_real = res_re[6];
  assign out7_real = res_re[7];
  assign out0_imag = res_im[0];
  assign out1_imag = res_im[1];
  assign out2_imag = res_im[2];
  assign out3_imag = res_im[3];
  assign out4_imag = res_im[4];
  assign out5_imag = res_im[5];
  assign out6_imag = res_im[6];
  assign out7_imag = res_im[7];

endmodule

// File: doc/eight_point_ifft.md
Name: eight_point_ifft

Overview:
Iterative 8-point radix-2 DIT inverse FFT. It is the reverse-direction partner of eight_point_fft and uses the same parallel load/start/ready command interface. One shared butterfly unit processes 3 stages × 4 butterflies over 12 cycles. Each stage scales by 1/2, so the output is x[n] = (1/8)·Σ X[k]·e^{+j2πnk/8} in Q8.8.

Parameters:
DATA_W, 16, sample component width (signed two's complement)
FRAC_W, 8, fractional bits of data and twiddles (Q8.8)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
in0_real..in7_real  in  DATA_W each  frequency-bin real parts X[0..7]
in0_imag..in7_imag  in  DATA_W each  frequency-bin imaginary parts
write  in  1  load in* into working registers (bit-reversed order)
start  in  1  begin transform on working registers
out0_real..out7_real  out  DATA_W each  time-domain real results x[0..7]
out0_imag..out7_imag  out  DATA_W each  time-domain imaginary results
ready  out  1  results valid

Behaviour:
- Interface fixed: one clock CLK; reset RST is asynchronous and active-high.
- RST high: state=IDLE, working regs=0, all out*=0, ready=0, butterfly counter=0. Reset mid-COMPUTE aborts immediately.
- States are IDLE, COMPUTE and DONE. DONE accepts commands exactly like IDLE.
- IDLE/DONE with write=1: the working reg at bitrev(k) takes in_k. ready goes to 0. State becomes IDLE. start is ignored in the same cycle (write wins).
- IDLE/DONE with start=1 and write=0: ready goes to 0, counter=0, state becomes COMPUTE. Start without a prior write transforms the current contents (zeros after reset).
- COMPUTE: one butterfly per cycle, counter c=0..11.
  - Stage s=c[3:2], j=c[1:0], h=1<<s.
  - top=(j>>s)·2h+(j&(h-1)), bot=top+h, twiddle index t=(j&(h-1))<<(2-s).
- write and start are ignored during COMPUTE.
- After c=11: out* are registered from the working regs, ready=1, state becomes DONE.
- Latency: ready rises on the 13th rising edge after the edge that samples start. It stays high until the next accepted write or start, or until reset.
- out* hold their last result until the next completion or reset.
- Twiddles are conjugate W8^t in Q8.8: t0=(256,0), t1=(181,181), t2=(0,256), t3=(−181,181).
- Butterfly arithmetic:
  - p = b·w as 32-bit products; each real/imag part is arithmetic-shifted right by FRAC_W (truncate toward −∞).
  - a' = (a+p)>>>1 and b' = (a−p)>>>1, computed in 18 bits.
  - Saturate to [−32768, 32767] before write-back.
- Overflow-free when every |input component| < 2^14. Beyond that, results saturate and do not wrap.

Decomposition:
- Package fft_pkg: DATA_W/FRAC_W defaults, conjugate twiddle constant table (4 entries), state encoding, bitrev3 function.
- Sub-module ifft_butterfly: combinational complex multiply, add/sub, scale by 1/2 and saturate. It is reusable by a future iterative forward FFT via non-conjugated twiddles.
- The top level holds the FSM, counter, address generation, working register file and output registers.

Test Plan:
- Reset: assert RST mid-sim -> all out*=0, ready=0 asynchronously; deassert -> still 0, state IDLE.
- Impulse X[0]=(0x0800,0), rest 0; write, then start -> ready on 13th edge; every out_n=(0x0100,0x0000).
- Single tone X[1]=(0x0800,0) -> out0=(256,0), out1=(181,181), out2=(0,256), out3=(−181,181), out4=(−256,0), out5=(−181,−181), out6=(0,−256), out7=(181,−181), all exact.
- Ramp X[k]=(k·256,0) -> out0=(896,0), out4=(−128,0), out2=(−128,−128) ±2 LSB, out6=(−128,128) ±2 LSB; outputs are conjugate-symmetric.
- Full scale: all X real=0x7FFF -> out0=(32767,0), others (0,0), no wrap. X[0]=(0x7FFF,0x7FFF), X[1]=(0x7FFF,0) -> out1/out3/out5/out7 equal their saturated expected values and never change sign.
- Protocol:
  - write and start pulses during COMPUTE -> ignored; result unchanged, ready still on the 13th edge.
  - write+start in the same IDLE cycle -> load only, no compute.
  - start in DONE -> ready drops next edge, recomputes identical result.
  - RST at c=6 -> outputs 0, ready never rises.
